uart_apb_arbiter: RTL and testbench
===================================

// Module: uart_apb_arbiter
// PURPOSE
//  APB master that shares the UART APB slave interface between NUM_REQ byte-level requesters.
//  Round-robin arbitration; each granted request becomes one APB transfer (SETUP then ACCESS).
//  Write = push one byte to the UART TX FIFO; read = pop one byte from the UART RX FIFO.
//  Wait states come from the slave's PREADY. A timeout aborts a transfer that never gets PREADY.
// PARAMETERS
//  NUM_REQ    4        number of requesters (2..8)
//  UART_ADDR  32'h0    value driven on PADDR for every transfer
//  TIMEOUT    16       max ACCESS cycles without PREADY before abort (>=2)
// PORTS
//  pclk        in   1          clock; all logic on rising edge
//  PRESETn     in   1          reset, asynchronous, active-high (1 = reset)
//  req         in   NUM_REQ    per-requester transfer request, level
//  req_write   in   NUM_REQ    per-requester direction: 1 = write, 0 = read
//  req_wdata   in   8*NUM_REQ  per-requester write byte; requester i uses [8i+7:8i]
//  gnt         out  NUM_REQ    one-hot, 1-cycle pulse: request captured
//  done        out  NUM_REQ    one-hot, 1-cycle pulse: transfer finished
//  err         out  1          valid with done: 1 = transfer aborted by timeout
//  rdata       out  8          read byte; valid with done on a successful read
//  PADDR       out  32         APB address
//  PWDATA      out  32         APB write data: {24'h0, byte}
//  PSELx       out  1          APB select
//  PENABLE     out  1          APB enable
//  PWRITE      out  1          APB direction
//  PRDATA      in   32         APB read data; only [7:0] used
//  PREADY      in   1          APB ready from the UART slave
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0; gnt, done, err, PSELx, PENABLE, PWRITE = 0;
//    PWDATA=0, rdata=0, wait_cnt=0. PADDR is constant UART_ADDR.
//  FSM: IDLE -> SETUP -> ACCESS -> IDLE. All outputs are registered.
//  IDLE: if any req bit is 1, pick the winner: first set bit at or after rr_ptr, with
//    wrap-around. Latch idx, req_write[idx], req_wdata[idx]. Next cycle: gnt[idx]=1,
//    PSELx=1, PENABLE=0, PWRITE/PWDATA valid, state=SETUP.
//  SETUP: exactly 1 cycle. Next: PENABLE=1, state=ACCESS, wait_cnt=0.
//  ACCESS: PSELx, PENABLE, PWRITE and PWDATA stay stable.
//    If PREADY=1: next cycle PSELx=0, PENABLE=0, done[idx]=1, err=0.
//      On a read, rdata=PRDATA[7:0]. rr_ptr=(idx+1) mod NUM_REQ. state=IDLE.
//    Else if wait_cnt==TIMEOUT-1: same exit, but err=1 and rdata is held unchanged.
//    Else wait_cnt++.
//  Latency, zero wait states: req seen at edge 0; gnt and SETUP at edge 1; ACCESS at edge 2.
//    PREADY is sampled at edge 3; done follows at edge 3. Next arbitration is at edge 4
//    (IDLE spends 1 cycle). Back-to-back throughput is 1 transfer per 4 cycles.
//  Requester contract: data is captured at arbitration; req may drop after gnt.
//    A req still high after done is treated as a new transfer.
//  Fairness: with all req bits high, grants rotate 0,1,..,NUM_REQ-1,0,...
//    No requester waits more than NUM_REQ-1 transfers.
//  A requester that drops req before being granted is simply skipped.
//  req changes during SETUP/ACCESS are ignored until the FSM returns to IDLE.
//  Reset mid-transfer: PSELx and PENABLE drop immediately (asynchronous). No done pulse.
//    The transfer is lost and rr_ptr returns to 0.
//  PRDATA[31:8] is ignored. X on req_wdata of a non-winning requester must not propagate.
// STRUCTURE
//  Package uart_apb_pkg: state encoding localparams (ST_IDLE, ST_SETUP, ST_ACCESS)
//    and the PWDATA zero-extend width constant.
//  Sub-module rr_arbiter #(N): combinational round-robin picker.
//    Inputs req and ptr; outputs one-hot grant, encoded idx and any_req.
//  Top level: FSM, capture registers, wait counter, rr_ptr update.
// TESTING
//  1 Single write: req=4'b0010, req_write[1]=1, byte 8'hA5, PREADY=1.
//    -> gnt[1] at +1, PSELx at +1, PENABLE at +2, PWDATA=32'hA5, done[1] at +3, err=0.
//  2 Read with 3 wait states: req[2] read, PREADY high on the 4th ACCESS cycle,
//    PRDATA=32'hFFFF_FF3C -> done[2] at +6, rdata=8'h3C.
//  3 All 4 requesting continuously, PREADY=1 -> gnt order 0,1,2,3,0,
//    one transfer per 4 cycles.
//  4 Timeout: PREADY held 0 -> done[idx] and err=1 exactly TIMEOUT cycles after PENABLE rises.
//    PSELx then drops and rdata is unchanged.
//  5 Reset at the first ACCESS cycle -> PSELx=PENABLE=0 immediately, no done.
//    The next request after release is arbitrated starting from requester 0.
//  6 req[3] asserted during another requester's ACCESS and req[0] held ->
//    requester 3 is granted next if rr_ptr has passed 0; APB signals stay stable in ACCESS.

Source files
------------

// File: rtl/uart_apb_pkg.sv
// Shared definitions for the UART APB arbiter: FSM state encoding and APB data padding.
package uart_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  // PWDATA carries one byte zero-extended to the 32-bit APB bus
  localparam int PWDATA_PAD = 24;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping around.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any_req
);

  always_comb begin
    logic found;
    int   cand;
    grant   = '0;
    idx     = '0;
    found   = 1'b0;
    cand    = 0;
    any_req = |req;
    for (int i = 0; i < N; i++) begin
      cand = (int'(ptr) + i) % N;
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = IW'(cand);
      end
    end
    if (found) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/uart_apb_arbiter.sv
// APB master sharing the UART slave between NUM_REQ byte requesters, round-robin,
// with a wait-state timeout. The winner is captured one cycle before it is granted.
module uart_apb_arbiter
  import uart_apb_pkg::*;
#(
  parameter int          NUM_REQ   = 4,
  parameter logic [31:0] UART_ADDR = 32'h0,
  parameter int          TIMEOUT   = 16
) (
  input  logic                 pclk,
  input  logic                 PRESETn,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_write,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic                 err,
  output logic [7:0]           rdata,
  output logic [31:0]          PADDR,
  output logic [31:0]          PWDATA,
  output logic                 PSELx,
  output logic                 PENABLE,
  output logic                 PWRITE,
  input  logic [31:0]          PRDATA,
  input  logic                 PREADY
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT);

  state_t               state, state_nxt;
  logic [IW-1:0]        rr_ptr;
  logic                 cap_valid;
  logic [IW-1:0]        cap_idx;
  logic [NUM_REQ-1:0]   cap_grant;
  logic                 cap_write;
  logic [7:0]           cap_byte;
  logic [WW-1:0]        wait_cnt;
  logic [NUM_REQ-1:0]   arb_grant;
  logic [IW-1:0]        arb_idx;
  logic                 arb_any;
  logic                 capture;
  logic                 timeout_hit;
  logic                 finish;
  logic                 unused_prdata;

  logic [NUM_REQ-1:0]   gnt_nxt, done_nxt;
  logic                 err_nxt, psel_nxt, penable_nxt, pwrite_nxt;
  logic [7:0]           rdata_nxt;
  logic [31:0]          pwdata_nxt;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req     (req),
    .ptr     (rr_ptr),
    .grant   (arb_grant),
    .idx     (arb_idx),
    .any_req (arb_any)
  );

  assign PADDR         = UART_ADDR;
  assign unused_prdata = ^PRDATA[31:8];
  assign capture       = (state == ST_IDLE) && !cap_valid && arb_any;
  assign timeout_hit   = (wait_cnt == WW'(TIMEOUT - 1));
  assign finish        = (state == ST_ACCESS) && (PREADY || timeout_hit);

  always_ff @(posedge pclk or posedge PRESETn) begin
    if (PRESETn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (cap_valid) state_nxt = ST_SETUP;
      ST_SETUP:  state_nxt = ST_ACCESS;
      ST_ACCESS: if (PREADY || timeout_hit) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Only the winner's byte is selected, so undriven bytes of other requesters never reach PWDATA
  always_ff @(posedge pclk or posedge PRESETn) begin
    if (PRESETn) begin
      cap_valid <= 1'b0;
      cap_idx   <= '0;
      cap_grant <= '0;
      cap_write <= 1'b0;
      cap_byte  <= 8'h0;
      wait_cnt  <= '0;
      rr_ptr    <= '0;
    end else begin
      cap_valid <= capture;
      if (capture) begin
        cap_idx   <= arb_idx;
        cap_grant <= arb_grant;
        cap_write <= req_write[arb_idx];
        cap_byte  <= req_wdata[8*arb_idx +: 8];
      end
      if (state == ST_SETUP) wait_cnt <= '0;
      else if (state == ST_ACCESS && !PREADY && !timeout_hit) wait_cnt <= wait_cnt + WW'(1);
      if (finish) rr_ptr <= (cap_idx == IW'(NUM_REQ - 1)) ? '0 : cap_idx + IW'(1);
    end
  end

  always_comb begin
    gnt_nxt     = '0;
    done_nxt    = '0;
    err_nxt     = 1'b0;
    rdata_nxt   = rdata;
    psel_nxt    = PSELx;
    penable_nxt = PENABLE;
    pwrite_nxt  = PWRITE;
    pwdata_nxt  = PWDATA;
    case (state)
      ST_IDLE: if (cap_valid) begin
        gnt_nxt     = cap_grant;
        psel_nxt    = 1'b1;
        penable_nxt = 1'b0;
        pwrite_nxt  = cap_write;
        pwdata_nxt  = {{PWDATA_PAD{1'b0}}, cap_byte};
      end
      ST_SETUP: penable_nxt = 1'b1;
      ST_ACCESS: if (PREADY || timeout_hit) begin
        psel_nxt    = 1'b0;
        penable_nxt = 1'b0;
        done_nxt    = cap_grant;
        err_nxt     = !PREADY;
        if (PREADY && !cap_write) rdata_nxt = PRDATA[7:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge pclk or posedge PRESETn) begin
    if (PRESETn) begin
      gnt     <= '0;
      done    <= '0;
      err     <= 1'b0;
      rdata   <= 8'h0;
      PSELx   <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PWDATA  <= 32'h0;
    end else begin
      gnt     <= gnt_nxt;
      done    <= done_nxt;
      err     <= err_nxt;
      rdata   <= rdata_nxt;
      PSELx   <= psel_nxt;
      PENABLE <= penable_nxt;
      PWRITE  <= pwrite_nxt;
      PWDATA  <= pwdata_nxt;
    end
  end

endmodule

// File: tb/tb_uart_apb_arbiter.sv
// Bench for uart_apb_arbiter: directed and random transfers checked against a
// transaction-level model of arbitration order, timing offsets and read data.
module tb_uart_apb_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic           pclk = 1'b0;
  logic           PRESETn;
  logic [N-1:0]   req, req_write;
  logic [8*N-1:0] req_wdata;
  logic [N-1:0]   gnt, done;
  logic           err;
  logic [7:0]     rdata;
  logic [31:0]    PADDR, PWDATA, PRDATA;
  logic           PSELx, PENABLE, PWRITE, PREADY;

  int         total = 0;
  int         bad = 0;
  int         cycle = 0;
  int         last_gnt_cycle = 0;
  int         model_ptr = 0;
  logic [7:0] model_rdata = 8'h0;

  uart_apb_arbiter #(.NUM_REQ(N), .UART_ADDR(32'h0), .TIMEOUT(TO)) dut (
    .pclk      (pclk),
    .PRESETn   (PRESETn),
    .req       (req),
    .req_write (req_write),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PSELx     (PSELx),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cycle++;

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cycle, got, exp);
    end
  endtask

  // Requesters form a ring; the winner is the first requester met walking from the pointer
  function automatic int pickWinner(input logic [N-1:0] mask, input int ptr);
    for (int j = 0; j < N; j++)
      if (mask[(ptr + j) % N]) return (ptr + j) % N;
    return -1;
  endfunction

  // Called at a negedge while the arbiter is idle; the next posedge is the arbitration edge (k=0)
  task automatic applyStimulus(input logic [N-1:0] mask, input logic [N-1:0] writes,
                               input logic [8*N-1:0] wdata, input logic [31:0] prd,
                               input int waits, input bit check_spacing);
    int         win, done_at;
    logic [N-1:0] onehot;
    logic       wr, exp_psel, exp_pen, exp_err;
    logic [7:0] wbyte;
    logic [N-1:0] exp_gnt, exp_done;
    req       = mask;
    req_write = writes;
    req_wdata = wdata;
    PREADY    = 1'b0;
    PRDATA    = $urandom;
    win       = pickWinner(mask, model_ptr);
    onehot    = N'(1) << win;
    wr        = writes[win];
    wbyte     = wdata[8*win +: 8];
    done_at   = (waits < TO) ? 3 + waits : 2 + TO;
    for (int k = 0; k <= done_at; k++) begin
      @(posedge pclk);
      @(negedge pclk);
      if (k == 0) begin
        checkOutput("arb_edge", {gnt, PSELx}, {{N{1'b0}}, 1'b0});
        req       = N'($urandom);
        req_write = N'($urandom);
        req_wdata = $urandom;
      end else begin
        exp_psel = (k < done_at);
        exp_pen  = (k >= 2) && (k < done_at);
        exp_gnt  = (k == 1) ? onehot : '0;
        exp_done = (k == done_at) ? onehot : '0;
        exp_err  = (k == done_at) && (waits >= TO);
        checkOutput("ctrl", {gnt, done, err, PSELx, PENABLE},
                    {exp_gnt, exp_done, exp_err, exp_psel, exp_pen});
        if (exp_psel)
          checkOutput("apb", {PWRITE, PWDATA, PADDR}, {wr, 24'h0, wbyte, 32'h0});
        if (k == 1) begin
          if (check_spacing) checkOutput("spacing", cycle - last_gnt_cycle, 4);
          last_gnt_cycle = cycle;
        end
        if (k == done_at) begin
          if (waits < TO && !wr) model_rdata = prd[7:0];
          checkOutput("rdata", rdata, model_rdata);
          model_ptr = (win + 1) % N;
        end
      end
      if (waits < TO && k + 1 == done_at) begin
        PREADY = 1'b1;
        PRDATA = prd;
      end else begin
        PREADY = (k == 1) ? 1'($urandom) : 1'b0;
        PRDATA = $urandom;
      end
    end
    PREADY = 1'b0;
    req    = '0;
  endtask

  // Reset asserted asynchronously during the first ACCESS cycle of a transfer
  task automatic resetMidTransfer(input logic [N-1:0] mask);
    req       = mask;
    req_write = '0;
    req_wdata = $urandom;
    PREADY    = 1'b0;
    for (int k = 0; k < 3; k++) @(negedge pclk);
    checkOutput("pre_rst_access", {PSELx, PENABLE}, 2'b11);
    req = '0;
    #1 PRESETn = 1'b1;
    #1 checkOutput("rst_async", {PSELx, PENABLE}, 2'b00);
    for (int k = 0; k < 2; k++) begin
      @(negedge pclk);
      checkOutput("rst_no_done", done, '0);
    end
    PRESETn     = 1'b0;
    model_ptr   = 0;
    model_rdata = 8'h0;
    checkOutput("rst_rdata", rdata, 8'h0);
  endtask

  initial begin
    PRESETn   = 1'b1;
    req       = '0;
    req_write = '0;
    req_wdata = '0;
    PRDATA    = '0;
    PREADY    = 1'b0;
    repeat (3) @(negedge pclk);
    checkOutput("reset_ctrl", {gnt, done, err, PSELx, PENABLE, PWRITE}, '0);
    checkOutput("reset_data", {PWDATA, rdata, PADDR}, '0);
    PRESETn = 1'b0;
    repeat (2) @(negedge pclk);
    checkOutput("idle_quiet", {gnt, PSELx}, '0);

    applyStimulus(4'b0010, 4'b0010, 32'h0000_A500, 32'h0, 0, 1'b0);
    applyStimulus(4'b0100, 4'b0000, 32'h1122_3344, 32'hFFFF_FF3C, 3, 1'b0);
    applyStimulus(4'b0001, 4'b0000, 32'h5566_7788, 32'h0000_0099, TO, 1'b0);
    resetMidTransfer(4'b0100);
    applyStimulus(4'b1001, 4'b1001, $urandom, $urandom, 1, 1'b0);
    applyStimulus(4'b1111, 4'b1111, $urandom, $urandom, 0, 1'b0);
    for (int t = 0; t < 4; t++)
      applyStimulus(4'b1111, N'($urandom), $urandom, $urandom, 0, 1'b1);

    for (int t = 0; t < 40; t++)
      applyStimulus(N'($urandom_range(1, (1 << N) - 1)), N'($urandom), $urandom, $urandom,
                    ($urandom_range(0, 7) == 0) ? TO : int'($urandom_range(0, 5)), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
